// File: rtl/seg7_pkg.sv
// Shared constants and types for the eight-digit seven-segment scanner.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIG_W      = 3;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [SEG_W-1:0] HEX7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [SEG_W-1:0]      seg;
    logic                  dp;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: AN_OFF, seg: SEG_OFF, dp: 1'b1};

endpackage

// File: rtl/seg7_scan_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = HEX7[nibble_i];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed display driver with per-frame input snapshot.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_DIV = 131072
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           value,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic [31:0]           snap_val_q, snap_val_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic                  snap_lz_q, snap_lz_d;
  disp_t                 disp_q, disp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick_c;
  logic                  frame_end_c;
  logic                  blank_c;
  logic [3:0]            nibble_c;
  logic [SEG_W-1:0]      hex_seg_c;

  hex7seg u_hex7seg (
    .nibble_i (nibble_c),
    .seg_o    (hex_seg_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      dig_q        <= '0;
      snap_val_q   <= '0;
      snap_dp_q    <= '0;
      snap_lz_q    <= 1'b0;
      disp_q       <= DISP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      dig_q        <= dig_d;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      snap_lz_q    <= snap_lz_d;
      disp_q       <= disp_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Prescaler, digit counter and frame-boundary snapshot
  always_comb begin
    pre_d        = pre_q + PRE_W'(1);
    dig_d        = dig_q;
    snap_val_d   = snap_val_q;
    snap_dp_d    = snap_dp_q;
    snap_lz_d    = snap_lz_q;
    frame_done_d = 1'b0;

    tick_c      = (pre_q == PRE_W'(TICK_DIV - 1));
    frame_end_c = tick_c && (dig_q == DIG_W'(NUM_DIGITS - 1));

    if (tick_c) begin
      pre_d = '0;
      dig_d = dig_q + DIG_W'(1);
    end
    if (frame_end_c) begin
      snap_val_d   = value;
      snap_dp_d    = dp_mask;
      snap_lz_d    = blank_lz;
      frame_done_d = 1'b1;
    end
  end

  // Decode the current digit; outputs lag dig_q by one register stage
  always_comb begin
    disp_d   = DISP_OFF;
    nibble_c = snap_val_q[{dig_q, 2'b00} +: 4];
    blank_c  = snap_lz_q && (dig_q != '0) &&
               ((snap_val_q >> {dig_q, 2'b00}) == 32'd0);

    if (!blank_c) begin
      disp_d.an  = ~(NUM_DIGITS'(1) << dig_q);
      disp_d.seg = hex_seg_c;
      disp_d.dp  = ~snap_dp_q[dig_q];
    end
  end

  assign seg        = disp_q.seg;
  assign an         = disp_q.an;
  assign dp         = disp_q.dp;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomised self-checking bench for seg7_scan against a frame-level display model.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = '0;
  logic [7:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        dp;
  logic        frame_done;

  seg7_scan #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          n_checks = 0;
  int          n_fail   = 0;
  int          k        = 0;   // clock edges since reset released
  int          slot     = 0;   // digit the outputs show after this edge
  logic [31:0] m_val    = '0;
  logic [7:0]  m_dp     = '0;
  logic        m_lz     = 1'b0;
  logic [15:0] exp_disp = {8'hFF, 7'h7F, 1'b1};
  logic        exp_fd   = 1'b0;

  // What the display should show for digit d given a frame snapshot
  function automatic logic [15:0] model_disp(int d, logic [31:0] sv, logic [7:0] sd, logic sl);
    logic       dark;
    logic [7:0] a;
    dark = sl && (d != 0);
    for (int j = d; j < 8; j++)
      if (sv[4*j +: 4] != 4'h0) dark = 1'b0;
    if (dark) return {8'hFF, 7'h7F, 1'b1};
    a = 8'hFF;
    a[d] = 1'b0;
    return {a, HEX[sv[4*d +: 4]], ~sd[d]};
  endfunction

  // Advance one clock and update the model's expectations
  task automatic step();
    logic [31:0] v_in;
    logic [7:0]  d_in;
    logic        lz_in, r_in;
    v_in = value; d_in = dp_mask; lz_in = blank_lz; r_in = rst;
    @(posedge clk);
    if (r_in) begin
      k = 0; slot = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
      exp_disp = {8'hFF, 7'h7F, 1'b1};
      exp_fd = 1'b0;
    end else begin
      k++;
      slot = ((k - 1) / 4) % 8;
      exp_disp = model_disp(slot, m_val, m_dp, m_lz);
      exp_fd = (k % 32 == 0);
      if (exp_fd) begin
        m_val = v_in; m_dp = d_in; m_lz = lz_in;
      end
    end
    #1;
  endtask

  // Step until just after a sampling edge (next output is digit 0 of a new frame)
  task automatic run_to_frame_end(string name);
    int guard = 0;
    do begin
      step();
      guard++;
    end while (!(k > 0 && k % 32 == 0) && guard < 40);
    n_checks++;
    if (!(k > 0 && k % 32 == 0)) begin
      n_fail++;
      $display("FAIL %s frame boundary not reached: k=%0d", name, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    value = $urandom; dp_mask = 8'(($urandom)); blank_lz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_dark cyc=%0d: got an=%h seg=%h dp=%b fd=%b", i, an, seg, dp, frame_done);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame_done} !== {exp_disp, exp_fd}) begin
        n_fail++;
        $display("FAIL first_frame k=%0d: got %h exp %h", k, {an, seg, dp, frame_done}, {exp_disp, exp_fd});
      end
      if (i % 4 == 0) begin
        n_checks++;
        if (an !== ~(8'h01 << (i / 4)) || seg !== 7'h40) begin
          n_fail++;
          $display("FAIL first_frame_literal slot=%0d: got an=%h seg=%h", i / 4, an, seg);
        end
      end
    end
  endtask

  task automatic test_hex_readout();
    logic [6:0] want [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    int pulses = 0;
    value = 32'h89ABCDEF; blank_lz = 1'b0; dp_mask = 8'h00;
    run_to_frame_end("hex");
    for (int i = 0; i < 64; i++) begin
      step();
      if (frame_done) pulses++;
      n_checks++;
      if ({an, seg, dp, frame_done} !== {exp_disp, exp_fd}) begin
        n_fail++;
        $display("FAIL hex_model k=%0d: got %h exp %h", k, {an, seg, dp, frame_done}, {exp_disp, exp_fd});
      end
      if (i < 32 && i % 4 == 1) begin
        n_checks++;
        if (seg !== want[slot] || dp !== 1'b1) begin
          n_fail++;
          $display("FAIL hex_digit%0d: got seg=%h dp=%b exp seg=%h dp=1", slot, seg, dp, want[slot]);
        end
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL hex_frame_done_count: got %0d exp 2", pulses);
    end
  endtask

  task automatic test_blanking();
    value = 32'h0000_0A00; blank_lz = 1'b1; dp_mask = 8'h00;
    run_to_frame_end("blank");
    value = 32'h0;
    for (int i = 0; i < 64; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame_done} !== {exp_disp, exp_fd}) begin
        n_fail++;
        $display("FAIL blank_model k=%0d: got %h exp %h", k, {an, seg, dp, frame_done}, {exp_disp, exp_fd});
      end
      if (i % 4 == 2) begin
        n_checks++;
        if (i < 32 && slot == 2 && seg !== 7'h08) begin
          n_fail++;
          $display("FAIL blank_digit2: got seg=%h exp 08", seg);
        end else if (i < 32 && slot >= 3 && an !== 8'hFF) begin
          n_fail++;
          $display("FAIL blank_high slot=%0d: got an=%h exp FF", slot, an);
        end else if (i >= 32 && slot != 0 && an !== 8'hFF) begin
          n_fail++;
          $display("FAIL blank_zero slot=%0d: got an=%h exp FF", slot, an);
        end else if (i >= 32 && slot == 0 && (an !== 8'hFE || seg !== 7'h40)) begin
          n_fail++;
          $display("FAIL blank_zero_d0: got an=%h seg=%h exp FE 40", an, seg);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    value = 32'h11111111; blank_lz = 1'b0; dp_mask = 8'h00;
    run_to_frame_end("snap");
    for (int i = 0; i < 64; i++) begin
      step();
      if (i == 11) value = 32'h22222222;
      n_checks++;
      if ({an, seg, dp, frame_done} !== {exp_disp, exp_fd}) begin
        n_fail++;
        $display("FAIL snap_model k=%0d: got %h exp %h", k, {an, seg, dp, frame_done}, {exp_disp, exp_fd});
      end
      if (i % 4 == 3) begin
        n_checks++;
        if (seg !== (i < 32 ? 7'h79 : 7'h24)) begin
          n_fail++;
          $display("FAIL snap_literal i=%0d slot=%0d: got seg=%h exp %h", i, slot, seg, (i < 32 ? 7'h79 : 7'h24));
        end
      end
    end
  endtask

  task automatic test_decimal_point();
    value = 32'h12345678; dp_mask = 8'h05; blank_lz = 1'b0;
    run_to_frame_end("dp");
    value = 32'h1; dp_mask = 8'h80; blank_lz = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame_done} !== {exp_disp, exp_fd}) begin
        n_fail++;
        $display("FAIL dp_model k=%0d: got %h exp %h", k, {an, seg, dp, frame_done}, {exp_disp, exp_fd});
      end
      n_checks++;
      if (i < 32 && dp !== !(an == 8'hFE || an == 8'hFB)) begin
        n_fail++;
        $display("FAIL dp_mask05 an=%h: got dp=%b", an, dp);
      end else if (i >= 32 && slot == 7 && (an !== 8'hFF || dp !== 1'b1)) begin
        n_fail++;
        $display("FAIL dp_blanked_d7: got an=%h dp=%b exp FF 1", an, dp);
      end
    end
  endtask

  task automatic test_mid_reset();
    value = 32'hDEADBEEF; dp_mask = 8'hFF; blank_lz = 1'b0;
    run_to_frame_end("midrst");
    for (int i = 0; i < 21; i++) step();   // now showing digit 5
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({an, seg, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_dark: got an=%h seg=%h dp=%b fd=%b", an, seg, dp, frame_done);
    end
    for (int i = 1; i <= 32; i++) begin
      step();
      n_checks++;
      if ({an, seg, dp, frame_done} !== {exp_disp, exp_fd}) begin
        n_fail++;
        $display("FAIL midrst_model k=%0d: got %h exp %h", k, {an, seg, dp, frame_done}, {exp_disp, exp_fd});
      end
      if (i == 1 || i == 32) begin
        n_checks++;
        if (i == 1 && (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1 || frame_done !== 1'b0)) begin
          n_fail++;
          $display("FAIL midrst_restart: got an=%h seg=%h dp=%b fd=%b", an, seg, dp, frame_done);
        end else if (i == 32 && frame_done !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_frame_done: got %b exp 1 after 32 cycles", frame_done);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        value    = $urandom;
        if ($urandom_range(0, 1) == 1) value = value >> (4 * $urandom_range(0, 8));
        dp_mask  = 8'($urandom);
        blank_lz = 1'($urandom);
      end
      step();
      n_checks++;
      if ({an, seg, dp, frame_done} !== {exp_disp, exp_fd}) begin
        n_fail++;
        $display("FAIL random k=%0d: got %h exp %h", k, {an, seg, dp, frame_done}, {exp_disp, exp_fd});
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_readout();
    test_blanking();
    test_snapshot();
    test_decimal_point();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
